mem_stage: RTL and testbench
============================

# mem_stage

MEM stage of the ARMv8 five-stage pipeline: consumes the EX/MEM register outputs, resolves CBZ/CBNZ/B branches, runs a request/acknowledge transaction to data memory for LDUR/STUR, and registers the MEM/WB result toward write-back. Variable-latency memory is absorbed by a small FSM that holds the pipeline through `stall_req` while an access is outstanding.

## Interface
- `TIMEOUT_CYC`, 16: maximum BUSY cycles before a forced completion; range 1–255. Used only when `MEM_TIMEOUT_EN` is defined.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `mem_flags` in 4: NZCV; bit 2 = Z.
- `mem_result` in 64: ALU result, also the memory address.
- `mem_reg2` in 64: store data.
- `mem_waddr` in 5: destination register.
- `mem_MemRead`, `mem_MemWrite`, `mem_MemtoReg`, `mem_RegWrite` in 1 each: control.
- `mem_add_result` in 64: branch target.
- `mem_isZeroBranch`, `mem_isNZBranch`, `mem_isUnconBranch` in 1 each: branch type.
- `dmem_req` out 1: access request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 64.
- `dmem_wdata` out 64.
- `dmem_ack` in 1: completion; one cycle per request.
- `dmem_rdata` in 64: read data, valid with `dmem_ack`.
- `stall_req` out 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- `pc_src` out 1: take branch.
- `branch_target` out 64.
- `wb_wdata` out 64: write-back data, registered.
- `wb_waddr` out 5: registered.
- `wb_RegWrite` out 1: registered.
- `bus_err` out 1: sticky timeout flag.

## Operation
- Access: `acc = mem_MemRead | mem_MemWrite`. If both are set, treat it as a read with `dmem_we = 0`.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY when `acc`. On that edge, latch `dmem_addr = mem_result`, `dmem_wdata = mem_reg2` and `dmem_we = mem_MemWrite & ~mem_MemRead`.
  - BUSY: `dmem_req = 1`. When `dmem_ack`, latch `dmem_rdata` into `rdata_q` and go to DONE.
  - DONE: `dmem_req = 0`. Always returns to IDLE.
- `stall_req = (IDLE & acc) | BUSY`. This is combinational. It is 0 in DONE, so EX/MEM and MEM/WB both advance at the end of DONE.
- `dmem_addr`, `dmem_wdata` and `dmem_we` stay stable from the IDLE→BUSY edge until the next request.
- Branch logic, combinational, independent of the FSM:
  - `pc_src = mem_isUnconBranch | (mem_isZeroBranch & Z) | (mem_isNZBranch & ~Z)`.
  - `branch_target = mem_add_result`.
- MEM/WB register, updated each edge:
  - If `stall_req = 0`: `wb_wdata = mem_MemtoReg ? rdata_q : mem_result`; `wb_waddr = mem_waddr`; `wb_RegWrite = mem_RegWrite`.
  - If `stall_req = 1`: bubble, with `wb_RegWrite = 0` and the other wb fields held. A stalled instruction therefore writes back exactly once.
- Stores: `wb_RegWrite` follows `mem_RegWrite` (0 from decode); no rdata is used.

## Timing
- Reset (`rst = 0`), asynchronous:
  - State goes to IDLE.
  - `dmem_req`, `dmem_we`, `wb_RegWrite` and `bus_err` go to 0.
  - `dmem_addr`, `dmem_wdata`, `wb_wdata`, `rdata_q` and the timeout counter go to 0; `wb_waddr` goes to 0.
  - Reset mid-BUSY drops `dmem_req` immediately. Any late `dmem_ack` after reset is ignored in IDLE.
- Non-memory instruction: 1 cycle, no stall. `wb_*` is valid the cycle after it is in MEM.
- Memory access with ack on the first BUSY cycle: 3 cycles in MEM (IDLE-detect, BUSY, DONE), with `stall_req` high for 2 of them. Each extra wait cycle adds one.
- `dmem_ack` outside BUSY is ignored.
- Back-to-back accesses: the instruction arriving after DONE is seen in IDLE and starts a new transaction. There is no idle gap beyond the DONE cycle.
- Branches never access memory. `pc_src` is valid in the same cycle the branch is in MEM; the flush of younger stages is owned by the control unit.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on IDLE→BUSY and increments each BUSY cycle without ack.
  - When the count reaches `TIMEOUT_CYC`, the FSM goes to DONE with `rdata_q = 0` and `bus_err` is set.
  - `bus_err` stays set until reset.
- `MEM_TIMEOUT_EN` undefined: BUSY waits indefinitely, no counter is built, and `bus_err` is tied to 0.

## Test plan
- Reset: hold `rst = 0` while in BUSY with `dmem_req = 1` → `dmem_req`, `stall_req` and `wb_RegWrite` go to 0 immediately; after release the FSM is IDLE.
- LDUR: `mem_result = 0x100`, MemRead/MemtoReg/RegWrite = 1, `waddr = 9`, ack after 2 BUSY cycles with rdata `0xDEADBEEF` → `stall_req` is high for 3 cycles, `dmem_addr = 0x100`; one cycle after DONE, `wb_wdata = 0xDEADBEEF`, `wb_waddr = 9`, `wb_RegWrite = 1`, and `wb_RegWrite` was 0 in every earlier cycle.
- STUR followed immediately by LDUR, both with ack on the first BUSY cycle → two transactions: `dmem_we` = 1 then 0, `dmem_wdata = mem_reg2` on the store, total MEM occupancy 6 cycles.
- CBZ with `flags = 4'b0100` and `add_result = 0x400` → `pc_src = 1`, `branch_target = 0x400`. CBNZ with the same flags → `pc_src = 0`. B → `pc_src = 1` regardless of flags.
- ALU op with `result = 0x55`, `RegWrite = 1` → `stall_req = 0`; the next cycle `wb_wdata = 0x55` and `wb_RegWrite = 1`.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYC = 4`, never ack → DONE after 4 BUSY cycles, `bus_err = 1` sticky, load writes back 0.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if;
  localparam int unsigned XLEN = 64;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// ARMv8 MEM stage: branch resolve, variable-latency data-memory FSM with stall, MEM/WB register.
// Optional busy-timeout watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mem_flags,
  input  logic [63:0]       mem_result,
  input  logic [63:0]       mem_reg2,
  input  logic [4:0]        mem_waddr,
  input  logic              mem_MemRead,
  input  logic              mem_MemWrite,
  input  logic              mem_MemtoReg,
  input  logic              mem_RegWrite,
  input  logic [63:0]       mem_add_result,
  input  logic              mem_isZeroBranch,
  input  logic              mem_isNZBranch,
  input  logic              mem_isUnconBranch,
  mem_stage_if.master       dmem,
  output logic              stall_req,
  output logic              pc_src,
  output logic [63:0]       branch_target,
  output logic [63:0]       wb_wdata,
  output logic [4:0]        wb_waddr,
  output logic              wb_RegWrite,
  output logic              bus_err
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned RW   = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  state_e          r_state, w_state_nxt;
  logic            w_acc, w_start, w_timeout;
  logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
  logic            r_we;
  logic [XLEN-1:0] r_wb_wdata;
  logic [RW-1:0]   r_wb_waddr;
  logic            r_wb_regwrite;
  logic            w_unused_flags;

  assign w_acc          = mem_MemRead | mem_MemWrite;
  assign w_unused_flags = ^{mem_flags[3], mem_flags[1:0]};

  // Stall is forced low while reset is asserted so the front end is released at once.
  assign stall_req = rst & (((r_state == ST_IDLE) & w_acc) | (r_state == ST_BUSY));

  assign pc_src        = mem_isUnconBranch | (mem_isZeroBranch & mem_flags[2]) |
                         (mem_isNZBranch & ~mem_flags[2]);
  assign branch_target = mem_add_result;

  assign dmem.dmem_req   = (r_state == ST_BUSY);
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;

  assign wb_wdata    = r_wb_wdata;
  assign wb_waddr    = r_wb_waddr;
  assign wb_RegWrite = r_wb_regwrite;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: if (w_acc) begin
        w_state_nxt = ST_BUSY;
        w_start     = 1'b1;
      end
      ST_BUSY: if (dmem.dmem_ack || w_timeout) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request fields, read-data capture and MEM/WB register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr        <= '0;
      r_wdata       <= '0;
      r_we          <= 1'b0;
      r_rdata       <= '0;
      r_wb_wdata    <= '0;
      r_wb_waddr    <= '0;
      r_wb_regwrite <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr  <= mem_result;
        r_wdata <= mem_reg2;
        r_we    <= mem_MemWrite & ~mem_MemRead;
      end
      if (r_state == ST_BUSY) begin
        if (dmem.dmem_ack)  r_rdata <= dmem.dmem_rdata;
        else if (w_timeout) r_rdata <= '0;
      end
      if (!stall_req) begin
        r_wb_wdata    <= mem_MemtoReg ? r_rdata : mem_result;
        r_wb_waddr    <= mem_waddr;
        r_wb_regwrite <= mem_RegWrite;
      end else begin
        r_wb_regwrite <= 1'b0;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] r_cnt;
  logic       r_bus_err;

  // Fires on the BUSY cycle that would bring the count to TIMEOUT_CYC.
  assign w_timeout = (r_state == ST_BUSY) & ~dmem.dmem_ack & (r_cnt == TO_LAST);
  assign bus_err   = r_bus_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_start)                                       r_cnt <= '0;
      else if ((r_state == ST_BUSY) && !dmem.dmem_ack)   r_cnt <= r_cnt + 8'd1;
      if (w_timeout) r_bus_err <= 1'b1;
    end
  end
`else
  logic [7:0] w_unused_to;

  assign w_unused_to = 8'(TIMEOUT_CYC);
  assign w_timeout   = 1'b0;
  assign bus_err     = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions, memory responder, wb and dmem monitors.
module tb_mem_stage;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 16;
`endif

  typedef struct { logic [63:0] data; logic [4:0] addr; } wb_t;
  typedef struct { logic [63:0] addr; logic we; logic [63:0] wdata; } dm_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  flags;
  logic [63:0] result, reg2, add_result;
  logic [4:0]  waddr;
  logic        mrd, mwr, m2r, rwr, isz, isnz, isun;
  logic        stall_req, pc_src, wb_RegWrite, bus_err;
  logic [63:0] branch_target, wb_wdata;
  logic [4:0]  wb_waddr;

  mem_stage_if dmem_if ();

  mem_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .mem_flags(flags), .mem_result(result), .mem_reg2(reg2),
    .mem_waddr(waddr), .mem_MemRead(mrd), .mem_MemWrite(mwr), .mem_MemtoReg(m2r),
    .mem_RegWrite(rwr), .mem_add_result(add_result), .mem_isZeroBranch(isz),
    .mem_isNZBranch(isnz), .mem_isUnconBranch(isun), .dmem(dmem_if),
    .stall_req(stall_req), .pc_src(pc_src), .branch_target(branch_target),
    .wb_wdata(wb_wdata), .wb_waddr(wb_waddr), .wb_RegWrite(wb_RegWrite), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  wb_t   wb_q[$];
  dm_t   dm_q[$];
  int    ack_wait = 0;
  logic [63:0] resp_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: ack on the ack_wait-th BUSY cycle (0 = never).
  initial begin
    int busy_cnt;
    busy_cnt = 0;
    dmem_if.dmem_ack   = 1'b0;
    dmem_if.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (dmem_if.dmem_req) begin
        busy_cnt++;
        dmem_if.dmem_ack   = (busy_cnt == ack_wait);
        dmem_if.dmem_rdata = (busy_cnt == ack_wait) ? resp_data : 64'hBAD0_BAD0_BAD0_BAD0;
      end else begin
        busy_cnt = 0;
        dmem_if.dmem_ack = 1'b0;
      end
    end
  end

  // Write-back monitor.
  always @(negedge clk) begin
    if (rst && wb_RegWrite) begin
      if (wb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected: got waddr %0d data 0x%0h expected no write-back", wb_waddr, wb_wdata);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        check("wb_wdata", wb_wdata, e.data);
        check("wb_waddr", 64'(wb_waddr), 64'(e.addr));
      end
    end
  end

  // Data-memory request monitor: checks each new request against the expected transaction.
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (rst && dmem_if.dmem_req && !prev_req) begin
      if (dm_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dmem_unexpected: got addr 0x%0h expected no request", dmem_if.dmem_addr);
      end else begin
        dm_t e;
        e = dm_q.pop_front();
        check("dmem_addr", dmem_if.dmem_addr, e.addr);
        check("dmem_we", 64'(dmem_if.dmem_we), 64'(e.we));
        check("dmem_wdata", dmem_if.dmem_wdata, e.wdata);
      end
    end
    prev_req = dmem_if.dmem_req;
  end

  task automatic set_idle();
    flags = '0; result = '0; reg2 = '0; add_result = '0; waddr = '0;
    mrd = 0; mwr = 0; m2r = 0; rwr = 0; isz = 0; isnz = 0; isun = 0;
  endtask

  // Present one instruction in MEM until the stage releases it; count stalled cycles.
  task automatic issue(input string nm, input logic rd, input logic wr, input logic mr,
                       input logic rw, input logic [63:0] res, input logic [63:0] r2,
                       input logic [4:0] wa, input logic [63:0] rdata, input int ackw,
                       input int exp_stall);
    int cyc;
    set_idle();
    mrd = rd; mwr = wr; m2r = mr; rwr = rw; result = res; reg2 = r2; waddr = wa;
    ack_wait = ackw; resp_data = rdata;
    if (rd || wr) dm_q.push_back('{addr: res, we: wr & ~rd, wdata: r2});
    if (rw) wb_q.push_back('{data: mr ? ((ackw == 0) ? 64'd0 : rdata) : res, addr: wa});
    cyc = 0;
    @(negedge clk);
    while (stall_req && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check({nm, "_stall_cycles"}, 64'(cyc), 64'(exp_stall));
    @(posedge clk); #1;
  endtask

  task automatic branch(input string nm, input logic z, input logic nz, input logic un,
                        input logic [3:0] fl, input logic [63:0] tgt, input logic exp_pc);
    set_idle();
    isz = z; isnz = nz; isun = un; flags = fl; add_result = tgt;
    @(negedge clk);
    check({nm, "_pc_src"}, 64'(pc_src), 64'(exp_pc));
    check({nm, "_target"}, branch_target, tgt);
    check({nm, "_stall"}, 64'(stall_req), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    #3;
    check("rst_req", 64'(dmem_if.dmem_req), 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_wb_regwrite", 64'(wb_RegWrite), 64'd0);
    check("rst_wb_wdata", wb_wdata, 64'd0);
    check("rst_bus_err", 64'(bus_err), 64'd0);
    check("rst_addr", dmem_if.dmem_addr, 64'd0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset asserted while BUSY: load is abandoned, no write-back.
    set_idle();
    mrd = 1; m2r = 1; rwr = 1; result = 64'h300; reg2 = 64'h77; waddr = 5'd2;
    ack_wait = 0;
    dm_q.push_back('{addr: 64'h300, we: 1'b0, wdata: 64'h77});
    @(negedge clk);
    @(negedge clk);
    check("busy_req", 64'(dmem_if.dmem_req), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_req", 64'(dmem_if.dmem_req), 64'd0);
    check("midrst_stall", 64'(stall_req), 64'd0);
    check("midrst_wb_regwrite", 64'(wb_RegWrite), 64'd0);
    set_idle();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_req", 64'(dmem_if.dmem_req), 64'd0);
    check("post_rst_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;

    // LDUR with ack on the second BUSY cycle.
    issue("ldur", 1, 0, 1, 1, 64'h100, 64'h0, 5'd9, 64'hDEAD_BEEF, 2, 3);
    // STUR then LDUR back to back, each acked on the first BUSY cycle.
    issue("stur", 0, 1, 0, 0, 64'h200, 64'hCAFE_F00D, 5'd7, 64'h0, 1, 2);
    issue("ldur2", 1, 0, 1, 1, 64'h208, 64'h1111, 5'd4, 64'h1234_5678, 1, 2);
    // Read and write both set behaves as a read.
    issue("rdwr", 1, 1, 0, 0, 64'h318, 64'h2222, 5'd6, 64'h5, 1, 2);
    // ALU op, no memory.
    issue("alu", 0, 0, 0, 1, 64'h55, 64'h0, 5'd3, 64'h0, 1, 0);

    branch("cbz", 1, 0, 0, 4'b0100, 64'h400, 1'b1);
    branch("cbnz", 0, 1, 0, 4'b0100, 64'h400, 1'b0);
    branch("cbnz_nz", 0, 1, 0, 4'b1011, 64'h480, 1'b1);
    branch("b", 0, 0, 1, 4'b0000, 64'h800, 1'b1);

`ifdef MEM_TIMEOUT_EN
    issue("timeout_ld", 1, 0, 1, 1, 64'h500, 64'h0, 5'd5, 64'hFFFF, 0, 5);
`endif
    issue("alu2", 0, 0, 0, 1, 64'hA5A5, 64'h0, 5'd12, 64'h0, 1, 0);
    issue("nop1", 0, 0, 0, 0, 64'h0, 64'h0, 5'd0, 64'h0, 1, 0);
    issue("nop2", 0, 0, 0, 0, 64'h0, 64'h0, 5'd0, 64'h0, 1, 0);

`ifdef MEM_TIMEOUT_EN
    check("bus_err_sticky", 64'(bus_err), 64'd1);
`else
    check("bus_err_tied", 64'(bus_err), 64'd0);
`endif
    check("wb_queue_drained", 64'(wb_q.size()), 64'd0);
    check("dmem_queue_drained", 64'(dm_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
